// File: rtl/snn_pkg.sv
// Shared spiking-neural-network definitions: data widths, synapse FSM
// states and the unsigned 8-bit saturation used on the current word.
package snn_pkg;

    localparam int CUR_W = 8;
    localparam int WT_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INTEGRATE = 2'd1,
        REFRAC    = 2'd2
    } syn_state_t;

    // Clamp a signed value into 0..255 so inhibition never wraps upward
    // and heavy excitation never wraps downward.
    function automatic logic [CUR_W-1:0] sat_u8(input logic signed [15:0] s);
        logic [CUR_W-1:0] r;
        if (s[15])
            r = '0;
        else if (s > 16'sd255)
            r = '1;
        else
            r = s[CUR_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/syn_current_drive_if.sv
// Bundle of spike, weight-write and current signals for syn_current_drive.
// Optional spike_cnt member present when SYN_SPIKE_CNT_EN is defined.
interface syn_current_drive_if
    import snn_pkg::*;
#(
    parameter int N_IN = 4
);
    localparam int AW = $clog2(N_IN);

    logic [N_IN-1:0]  spike_in;
    logic             post_spike;
    logic             wt_valid;
    logic             wt_ready;
    logic [AW-1:0]    wt_addr;
    logic [WT_W-1:0]  wt_data;
    logic [CUR_W-1:0] current;
    logic             refrac;
`ifdef SYN_SPIKE_CNT_EN
    logic [15:0]      spike_cnt;
`endif

    // Upstream side: spike sources and the weight writer.
    modport master (
`ifdef SYN_SPIKE_CNT_EN
        input  spike_cnt,
`endif
        output spike_in, post_spike, wt_valid, wt_addr, wt_data,
        input  wt_ready, current, refrac
    );

    // Synapse block side.
    modport slave (
`ifdef SYN_SPIKE_CNT_EN
        output spike_cnt,
`endif
        input  spike_in, post_spike, wt_valid, wt_addr, wt_data,
        output wt_ready, current, refrac
    );

endinterface

// File: rtl/syn_weight_sum.sv
// Combinational masked signed sum of the weights whose spike input is set.
// With SYN_SPIKE_CNT_EN defined it also provides the popcount of i_spike.
module syn_weight_sum
    import snn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SUM_W = 12,
    parameter int PC_W  = 3
) (
    input  logic [N_IN-1:0][WT_W-1:0] i_wt,
    input  logic [N_IN-1:0]           i_spike,
`ifdef SYN_SPIKE_CNT_EN
    output logic [PC_W-1:0]           o_popcnt,
`endif
    output logic signed [SUM_W-1:0]   o_sum
);

    logic signed [SUM_W-1:0] w_term [N_IN];
    logic signed [SUM_W-1:0] w_part [N_IN+1];

    assign w_part[0] = '0;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_term
            // Sign-extend the weight only when its input spiked.
            assign w_term[gi]   = i_spike[gi] ?
                                  {{(SUM_W-WT_W){i_wt[gi][WT_W-1]}}, i_wt[gi]} : '0;
            assign w_part[gi+1] = w_part[gi] + w_term[gi];
        end
    endgenerate

    assign o_sum = w_part[N_IN];

`ifdef SYN_SPIKE_CNT_EN
    logic [PC_W-1:0] w_cnt [N_IN+1];

    assign w_cnt[0] = '0;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_pop
            assign w_cnt[gi+1] = w_cnt[gi] + {{(PC_W-1){1'b0}}, i_spike[gi]};
        end
    endgenerate

    assign o_popcnt = w_cnt[N_IN];
`endif

endmodule

// File: rtl/syn_current_drive.sv
// Presynaptic current drive: decaying synaptic trace plus signed per-input
// weights, saturated to an 8-bit current, with a post-spike refractory hold.
// Optional feature macro: SYN_SPIKE_CNT_EN (accepted-spike counter output).
module syn_current_drive
    import snn_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int DECAY_SHIFT   = 1,
    parameter int REFRAC_CYCLES = 4,
    parameter int WT_RESET      = 32
) (
    input  logic              clk,
    input  logic              rst,
    syn_current_drive_if.slave bus
);

    localparam int AW    = $clog2(N_IN);
    localparam int SUM_W = CUR_W + $clog2(N_IN) + 2;
    localparam int CNT_W = $clog2(REFRAC_CYCLES + 1);
    localparam int PC_W  = $clog2(N_IN + 1);
    localparam logic [WT_W-1:0] WT_INIT = WT_RESET[WT_W-1:0];

    syn_state_t                 r_state, w_state_next;
    logic [CUR_W-1:0]           r_current, w_current_next;
    logic [CNT_W-1:0]           r_cnt, w_cnt_next;
    logic [N_IN-1:0][WT_W-1:0]  r_wt;

    logic signed [SUM_W-1:0]    w_wsum;
    logic signed [SUM_W-1:0]    w_sum;
    logic [CUR_W-1:0]           w_sat;
    logic [CUR_W-1:0]           w_decay;
    logic                       w_wr_en;

    assign bus.wt_ready = (r_state != INTEGRATE);
    assign bus.current  = r_current;
    assign bus.refrac   = (r_state == REFRAC);
    assign w_wr_en      = bus.wt_valid && bus.wt_ready;

    assign w_decay = r_current >> DECAY_SHIFT;
    assign w_sum   = $signed({{(SUM_W-CUR_W){1'b0}}, w_decay}) + w_wsum;
    assign w_sat   = sat_u8({{(16-SUM_W){w_sum[SUM_W-1]}}, w_sum});

`ifdef SYN_SPIKE_CNT_EN
    logic [PC_W-1:0] w_popcnt;
    logic [16:0]     w_cnt_sum;
    logic [15:0]     r_spike_cnt;

    syn_weight_sum #(.N_IN(N_IN), .SUM_W(SUM_W), .PC_W(PC_W)) u_wsum (
        .i_wt     (r_wt),
        .i_spike  (bus.spike_in),
        .o_popcnt (w_popcnt),
        .o_sum    (w_wsum)
    );

    assign w_cnt_sum     = {1'b0, r_spike_cnt} + {{(17-PC_W){1'b0}}, w_popcnt};
    assign bus.spike_cnt = r_spike_cnt;

    // Count spikes that actually reach the trace; refractory drops excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_spike_cnt <= '0;
        else if (!bus.post_spike && r_state != REFRAC)
            r_spike_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
`else
    syn_weight_sum #(.N_IN(N_IN), .SUM_W(SUM_W), .PC_W(PC_W)) u_wsum (
        .i_wt    (r_wt),
        .i_spike (bus.spike_in),
        .o_sum   (w_wsum)
    );
`endif

    // Weight table; writes land only outside integration. Addresses past
    // N_IN match no entry and are silently discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++)
                r_wt[k] <= WT_INIT;
        end else if (w_wr_en) begin
            for (int k = 0; k < N_IN; k++)
                if (bus.wt_addr == k[AW-1:0])
                    r_wt[k] <= bus.wt_data;
        end
    end

    // State, current and refractory counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_current <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_current <= w_current_next;
            r_cnt     <= w_cnt_next;
        end
    end

    // Next-state logic; post_spike overrides everything and drops spikes.
    always_comb begin
        w_state_next   = r_state;
        w_current_next = r_current;
        w_cnt_next     = r_cnt;
        if (bus.post_spike) begin
            w_state_next   = REFRAC;
            w_current_next = '0;
            w_cnt_next     = CNT_W'(REFRAC_CYCLES);
        end else begin
            case (r_state)
                IDLE: begin
                    w_current_next = w_sat;
                    if (|bus.spike_in)
                        w_state_next = INTEGRATE;
                end
                INTEGRATE: begin
                    w_current_next = w_sat;
                    if (w_sat == '0 && bus.spike_in == '0)
                        w_state_next = IDLE;
                end
                REFRAC: begin
                    w_current_next = '0;
                    w_cnt_next     = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        w_state_next = IDLE;
                end
                default: begin
                    w_state_next   = IDLE;
                    w_current_next = '0;
                    w_cnt_next     = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syn_current_drive.sv
// Directed self-checking bench for syn_current_drive (default build).
module tb_syn_current_drive;
    import snn_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    syn_current_drive_if #(.N_IN(4)) bus ();

    syn_current_drive #(
        .N_IN(4), .DECAY_SHIFT(1), .REFRAC_CYCLES(4), .WT_RESET(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        bus.spike_in   = '0;
        bus.post_spike = 1'b0;
        repeat (12) tick();
    endtask

    task automatic write_wt(input logic [1:0] addr, input logic [7:0] data);
        bit done;
        done = 1'b0;
        bus.wt_valid = 1'b1;
        bus.wt_addr  = addr;
        bus.wt_data  = data;
        for (int n = 0; n < 20 && !done; n++) begin
            if (bus.wt_ready) done = 1'b1;
            tick();
        end
        bus.wt_valid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL write_wt timeout addr=%0d: accepted=0 required=1", addr);
        end else
            $display("[TB] write wt[%0d] = %0d", addr, $signed(data));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.spike_in = '0; bus.post_spike = 1'b0;
        bus.wt_valid = 1'b0; bus.wt_addr = '0; bus.wt_data = '0;
        repeat (2) tick();
        rst = 1'b0;
        bus.spike_in = 4'b0001;
        tick();
        n_tests++;
        if (bus.current !== 8'd32) begin n_fail++;
            $display("FAIL reset_first_spike: current=%0d required=32", bus.current); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.current !== 8'd0) begin n_fail++;
            $display("FAIL async_reset_current: current=%0d required=0", bus.current); end
        n_tests++;
        if (bus.refrac !== 1'b0) begin n_fail++;
            $display("FAIL async_reset_refrac: refrac=%b required=0", bus.refrac); end
        n_tests++;
        if (bus.wt_ready !== 1'b1) begin n_fail++;
            $display("FAIL async_reset_ready: wt_ready=%b required=1", bus.wt_ready); end
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.current !== 8'd32) begin n_fail++;
            $display("FAIL post_reset_spike: current=%0d required=32", bus.current); end
        $display("[TB] reset: current=%0d after spike on input 0", bus.current);
        flush();
    endtask

    task automatic test_decay();
        logic [7:0] exp_cur [7];
        exp_cur = '{8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1, 8'd0};
        bus.spike_in = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.spike_in = '0;
            n_tests++;
            if (bus.current !== exp_cur[i]) begin n_fail++;
                $display("FAIL decay[%0d]: current=%0d required=%0d", i, bus.current, exp_cur[i]); end
            if (i == 2) begin
                n_tests++;
                if (bus.wt_ready !== 1'b0) begin n_fail++;
                    $display("FAIL decay_ready_busy: wt_ready=%b required=0", bus.wt_ready); end
            end
        end
        n_tests++;
        if (bus.wt_ready !== 1'b1) begin n_fail++;
            $display("FAIL decay_ready_idle: wt_ready=%b required=1", bus.wt_ready); end
        $display("[TB] decay: trace returned to %0d", bus.current);
    endtask

    task automatic test_saturation();
        for (int a = 0; a < 4; a++) write_wt(a[1:0], 8'd100);
        bus.spike_in = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.current !== 8'd255) begin n_fail++;
                $display("FAIL saturate[%0d]: current=%0d required=255", i, bus.current); end
        end
        bus.spike_in = '0;
        tick();
        n_tests++;
        if (bus.current !== 8'd127) begin n_fail++;
            $display("FAIL saturate_decay1: current=%0d required=127", bus.current); end
        tick();
        n_tests++;
        if (bus.current !== 8'd63) begin n_fail++;
            $display("FAIL saturate_decay2: current=%0d required=63", bus.current); end
        $display("[TB] saturation: current held at 255, decayed to %0d", bus.current);
        flush();
    endtask

    task automatic test_inhibition();
        write_wt(2'd0, 8'd40);
        write_wt(2'd1, 8'hC0);
        bus.spike_in = 4'b0001;
        tick();
        n_tests++;
        if (bus.current !== 8'd40) begin n_fail++;
            $display("FAIL inhibit_charge: current=%0d required=40", bus.current); end
        bus.spike_in = 4'b0010;
        tick();
        n_tests++;
        if (bus.current !== 8'd0) begin n_fail++;
            $display("FAIL inhibit_clamp: current=%0d required=0", bus.current); end
        bus.spike_in = '0;
        tick();
        n_tests++;
        if (bus.wt_ready !== 1'b1) begin n_fail++;
            $display("FAIL inhibit_idle: wt_ready=%b required=1", bus.wt_ready); end
        $display("[TB] inhibition: 20-64 clamped to %0d", bus.current);
    endtask

    task automatic test_refractory();
        bus.spike_in   = 4'hF;
        bus.post_spike = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.post_spike = 1'b0;
            n_tests++;
            if (bus.current !== 8'd0) begin n_fail++;
                $display("FAIL refrac_cur[%0d]: current=%0d required=0", i, bus.current); end
            n_tests++;
            if (bus.refrac !== (i < 4)) begin n_fail++;
                $display("FAIL refrac_flag[%0d]: refrac=%b required=%b", i, bus.refrac, (i < 4)); end
        end
        tick();
        n_tests++;
        if (bus.current !== 8'd176) begin n_fail++;
            $display("FAIL refrac_resume: current=%0d required=176", bus.current); end
        $display("[TB] refractory: spikes resumed, current=%0d", bus.current);
        flush();
        bus.spike_in = 4'hF;
        for (int i = 0; i < 7; i++) begin
            bus.post_spike = (i == 0 || i == 2);
            tick();
            n_tests++;
            if (bus.refrac !== (i < 6) || bus.current !== 8'd0) begin n_fail++;
                $display("FAIL refrac_extend[%0d]: refrac=%b current=%0d required refrac=%b current=0",
                         i, bus.refrac, bus.current, (i < 6)); end
        end
        bus.post_spike = 1'b0;
        bus.spike_in   = '0;
        tick();
        $display("[TB] refractory: reload extended hold, refrac=%b", bus.refrac);
    endtask

    task automatic test_handshake();
        logic [7:0] exp_cur [6];
        exp_cur = '{8'd20, 8'd10, 8'd5, 8'd2, 8'd1, 8'd0};
        bus.spike_in = 4'b0001;
        tick();
        n_tests++;
        if (bus.current !== 8'd40 || bus.wt_ready !== 1'b0) begin n_fail++;
            $display("FAIL hs_start: current=%0d wt_ready=%b required 40/0", bus.current, bus.wt_ready); end
        bus.spike_in = '0;
        bus.wt_valid = 1'b1;
        bus.wt_addr  = 2'd2;
        bus.wt_data  = 8'hF8;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (bus.current !== exp_cur[i] || bus.wt_ready !== (i == 5)) begin n_fail++;
                $display("FAIL hs_hold[%0d]: current=%0d wt_ready=%b required %0d/%b",
                         i, bus.current, bus.wt_ready, exp_cur[i], (i == 5)); end
        end
        tick();
        bus.wt_valid = 1'b0;
        $display("[TB] handshake: write wt[2]=-8 accepted after idle");
        bus.spike_in = 4'b0100;
        tick();
        n_tests++;
        if (bus.current !== 8'd0) begin n_fail++;
            $display("FAIL hs_new_weight: current=%0d required=0", bus.current); end
        bus.spike_in = '0;
        tick();
        bus.spike_in = 4'b0101;
        tick();
        n_tests++;
        if (bus.current !== 8'd32) begin n_fail++;
            $display("FAIL hs_mixed: current=%0d required=32", bus.current); end
        flush();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_decay();
        test_saturation();
        test_inhibition();
        test_refractory();
        test_handshake();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: finished=0 required=1");
        $fatal(1, "timeout");
    end

endmodule
